// File: rtl/cpu_mc_core_if.sv
// cpu_mc_core_if: req/ack memory port with split read/write data buses
interface cpu_mc_core_if #(
  parameter int ADDR_W = 30
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/cpu_mc_core.sv
// cpu_mc_core: multicycle 32-bit core on a req/ack memory port with trap/timeout halt and retire counter
module cpu_mc_core #(
  parameter int                ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255,
  parameter int                CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  cpu_mc_core_if.master    bus,
  output logic             halted_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] retired_o
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, AGEN, MEM, LOAD_WB, HALT} state_t;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  state_t            state_q;
  logic [31:0]       regs_q [16];
  logic [ADDR_W-1:0] pc_q, addr_q;
  logic [31:0]       ir_q, a_q, b_q, d_q, rdata_q, wdata_q, wait_q;
  logic              req_q, we_q, halted_q, bus_err_q;
  logic [CNT_W-1:0]  retired_q;
  logic [1:0]        form, op;
  logic [3:0]        rd, aluop, ra, rb;
  logic [31:0]       alu_y, link;
  logic [ADDR_W-1:0] pc_inc, target;
  logic              taken, to_hit, is_mem;

  function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return {31'd0, $signed(a) < $signed(b)};
      4'd9:    return {31'd0, a < b};
      default: return b;
    endcase
  endfunction

  always_comb begin
    form   = ir_q[31:30];
    op     = ir_q[29:28];
    rd     = ir_q[27:24];
    aluop  = ir_q[23:20];
    ra     = ir_q[19:16];
    rb     = ir_q[15:12];
    alu_y  = alu(aluop, a_q, b_q);
    pc_inc = pc_q + ADDR_W'(1);
    target = ADDR_W'(32'(pc_q) + {{8{ir_q[23]}}, ir_q[23:0]});
    link   = 32'(pc_inc);
    taken  = ir_q[29] ? (d_q == '0) : (d_q != '0);
    to_hit = (TIMEOUT != 0) && (wait_q == TO_LAST);
    is_mem = ^op;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      d_q       <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      wait_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        FETCH:
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= pc_q;
            wait_q <= '0;
          end else if (bus.mem_ack) begin
            req_q   <= 1'b0;
            ir_q    <= bus.mem_rdata;
            state_q <= DECODE;
          end
        DECODE: begin
          a_q      <= regs_q[ra];
          b_q      <= form[0] ? regs_q[rb] : {{16{ir_q[15]}}, ir_q[15:0]};
          d_q      <= regs_q[rd];
          halted_q <= form == 2'd3;
          state_q  <= form == 2'd3 ? HALT : (!form[1] && is_mem) ? AGEN : EXEC;
        end
        EXEC: begin
          if (form[1]) begin
            if (ir_q[28]) regs_q[15] <= link;
            pc_q <= taken ? target : pc_inc;
          end else begin
            regs_q[rd] <= alu_y;
            pc_q       <= pc_inc;
          end
          retired_q <= retired_q + 1'b1;
          state_q   <= FETCH;
        end
        AGEN: begin
          addr_q  <= ADDR_W'(alu_y);
          we_q    <= op[1];
          wdata_q <= d_q;
          state_q <= MEM;
        end
        MEM:
          if (!req_q) begin
            req_q  <= 1'b1;
            wait_q <= '0;
          end else if (bus.mem_ack) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (op[1]) begin
              retired_q <= retired_q + 1'b1;
              pc_q      <= pc_inc;
              state_q   <= FETCH;
            end else begin
              rdata_q <= bus.mem_rdata;
              state_q <= LOAD_WB;
            end
          end
        LOAD_WB: begin
          regs_q[rd] <= rdata_q;
          retired_q  <= retired_q + 1'b1;
          pc_q       <= pc_inc;
          state_q    <= FETCH;
        end
        default: ;
      endcase
      // an unacknowledged request ages here whichever state issued it
      if (req_q && !bus.mem_ack) begin
        if (to_hit) begin
          req_q     <= 1'b0;
          halted_q  <= 1'b1;
          bus_err_q <= 1'b1;
          state_q   <= HALT;
        end else begin
          wait_q <= wait_q + 32'd1;
        end
      end
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign halted_o      = halted_q;
  assign bus_err_o     = bus_err_q;
  assign retired_o     = retired_q;
endmodule

// File: tb/tb_cpu_mc_core.sv
// tb_cpu_mc_core: scoreboarded memory responder plus scenario tasks for cpu_mc_core
module tb_cpu_mc_core;
  typedef struct {logic we; logic [29:0] addr; logic [31:0] wdata;} acc_t;
  localparam logic [31:0] TRAP = 32'hC000_0000;
  logic        clk, rst;
  logic        halted, bus_err;
  logic [31:0] retired;
  int          checks = 0, failures = 0;
  int          delay = 0, rcnt = 0;
  bit          never_ack = 0;
  acc_t        exp_q[$];
  logic [31:0] mem [logic [29:0]];
  logic        fwe;
  logic [29:0] faddr;
  logic [31:0] fwd;

  cpu_mc_core_if #(.ADDR_W(30)) bif ();
  cpu_mc_core #(.ADDR_W(30), .RESET_PC(30'h100), .TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bif), .halted_o(halted), .bus_err_o(bus_err), .retired_o(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic acc_t rd_acc(input logic [29:0] a);
    return '{1'b0, a, 32'h0};
  endfunction

  function automatic acc_t wr_acc(input logic [29:0] a, input logic [31:0] d);
    return '{1'b1, a, d};
  endfunction

  // memory slave: acks after `delay` wait cycles and scoreboards each new access
  initial begin
    acc_t e;
    bif.mem_ack   = 1'b0;
    bif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bif.mem_ack = 1'b0;
      if (bif.mem_req) begin
        checks++;
        if (rcnt == 0) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_access we=%b addr=%h wdata=%h", bif.mem_we, bif.mem_addr, bif.mem_wdata);
          end else begin
            e = exp_q.pop_front();
            if (bif.mem_we !== e.we || bif.mem_addr !== e.addr || (e.we && bif.mem_wdata !== e.wdata)) begin
              failures++;
              $display("FAIL access got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                       bif.mem_we, bif.mem_addr, bif.mem_wdata, e.we, e.addr, e.wdata);
            end
          end
          fwe = bif.mem_we; faddr = bif.mem_addr; fwd = bif.mem_wdata;
        end else if (bif.mem_we !== fwe || bif.mem_addr !== faddr || bif.mem_wdata !== fwd) begin
          failures++;
          $display("FAIL req_stable got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                   bif.mem_we, bif.mem_addr, bif.mem_wdata, fwe, faddr, fwd);
        end
        if (!never_ack && rcnt >= delay) begin
          bif.mem_ack = 1'b1;
          if (bif.mem_we) mem[bif.mem_addr] = bif.mem_wdata;
          else bif.mem_rdata = mem.exists(bif.mem_addr) ? mem[bif.mem_addr] : 32'h0;
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  task automatic begin_run(input int d, input bit na);
    rst = 1'b0;
    @(negedge clk);
    mem.delete();
    exp_q.delete();
    delay = d;
    never_ack = na;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_halt(input int n);
    for (int i = 0; i < n && halted !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic load_store_prog();
    mem[30'h100] = 32'h0100_0005;
    mem[30'h101] = 32'h2100_0020;
    mem[30'h102] = 32'h1200_0020;
    mem[30'h103] = 32'h2200_0021;
    mem[30'h104] = TRAP;
    exp_q.push_back(rd_acc(30'h100));
    exp_q.push_back(rd_acc(30'h101));
    exp_q.push_back(wr_acc(30'h20, 32'd5));
    exp_q.push_back(rd_acc(30'h102));
    exp_q.push_back(rd_acc(30'h20));
    exp_q.push_back(rd_acc(30'h103));
    exp_q.push_back(wr_acc(30'h21, 32'd5));
    exp_q.push_back(rd_acc(30'h104));
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bif.mem_req, bif.mem_we, halted, bus_err} !== 4'b0 || bif.mem_addr !== 30'h0 ||
        bif.mem_wdata !== 32'h0 || retired !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h halted=%b bus_err=%b retired=%0d want all 0",
               bif.mem_req, bif.mem_we, bif.mem_addr, bif.mem_wdata, halted, bus_err, retired);
    end
    begin_run(0, 0);
    mem[30'h100] = TRAP;
    exp_q.push_back(rd_acc(30'h100));
    release_rst();
    @(posedge clk);
    #1;
    checks++;
    if (bif.mem_req !== 1'b1 || bif.mem_addr !== 30'h100 || bif.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL first_req got req=%b addr=%h we=%b want 1 100 0", bif.mem_req, bif.mem_addr, bif.mem_we);
    end
    wait_halt(50);
    checks++;
    if (halted !== 1'b1 || bus_err !== 1'b0 || retired !== 32'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_trap got halted=%b bus_err=%b retired=%0d pending=%0d want 1 0 0 0",
               halted, bus_err, retired, exp_q.size());
    end
  endtask

  task automatic test_load_store();
    begin_run(0, 0);
    load_store_prog();
    release_rst();
    repeat (16) @(negedge clk);
    checks++;
    if (retired !== 32'd2) begin
      failures++;
      $display("FAIL load_latency_before got retired=%0d want 2", retired);
    end
    @(negedge clk);
    checks++;
    if (retired !== 32'd3) begin
      failures++;
      $display("FAIL load_latency got retired=%0d want 3", retired);
    end
    wait_halt(100);
    checks++;
    if (halted !== 1'b1 || bus_err !== 1'b0 || retired !== 32'd4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL load_store_end got halted=%b bus_err=%b retired=%0d pending=%0d want 1 0 4 0",
               halted, bus_err, retired, exp_q.size());
    end
  endtask

  task automatic test_wait_states();
    begin_run(3, 0);
    load_store_prog();
    release_rst();
    wait_halt(300);
    checks++;
    if (halted !== 1'b1 || bus_err !== 1'b0 || retired !== 32'd4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wait_states_end got halted=%b bus_err=%b retired=%0d pending=%0d want 1 0 4 0",
               halted, bus_err, retired, exp_q.size());
    end
  endtask

  task automatic test_branch();
    begin_run(0, 0);
    mem[30'h100] = 32'hA0FF_FF10;
    mem[30'h010] = 32'hB300_0008;
    mem[30'h018] = 32'h2F00_0030;
    mem[30'h019] = TRAP;
    exp_q.push_back(rd_acc(30'h100));
    exp_q.push_back(rd_acc(30'h010));
    exp_q.push_back(rd_acc(30'h018));
    exp_q.push_back(wr_acc(30'h30, 32'h11));
    exp_q.push_back(rd_acc(30'h019));
    release_rst();
    wait_halt(100);
    checks++;
    if (halted !== 1'b1 || retired !== 32'd3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL branch_taken_link got halted=%b retired=%0d pending=%0d want 1 3 0", halted, retired, exp_q.size());
    end
    begin_run(0, 0);
    mem[30'h100] = 32'hA0FF_FF10;
    mem[30'h010] = 32'h9300_0008;
    mem[30'h011] = 32'h2F00_0031;
    mem[30'h012] = TRAP;
    exp_q.push_back(rd_acc(30'h100));
    exp_q.push_back(rd_acc(30'h010));
    exp_q.push_back(rd_acc(30'h011));
    exp_q.push_back(wr_acc(30'h31, 32'h11));
    exp_q.push_back(rd_acc(30'h012));
    release_rst();
    wait_halt(100);
    checks++;
    if (halted !== 1'b1 || retired !== 32'd3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL branch_not_taken_link got halted=%b retired=%0d pending=%0d want 1 3 0", halted, retired, exp_q.size());
    end
  endtask

  task automatic test_trap();
    int reqs = 0;
    begin_run(0, 0);
    mem[30'h100] = 32'hA0FF_FF40;
    mem[30'h040] = TRAP;
    exp_q.push_back(rd_acc(30'h100));
    exp_q.push_back(rd_acc(30'h040));
    release_rst();
    wait_halt(100);
    checks++;
    if (halted !== 1'b1 || bus_err !== 1'b0 || retired !== 32'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL trap got halted=%b bus_err=%b retired=%0d pending=%0d want 1 0 1 0",
               halted, bus_err, retired, exp_q.size());
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.mem_req === 1'b1) reqs++;
    end
    checks++;
    if (reqs != 0 || retired !== 32'd1) begin
      failures++;
      $display("FAIL trap_frozen got req_cycles=%0d retired=%0d want 0 1", reqs, retired);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    begin_run(0, 1);
    exp_q.push_back(rd_acc(30'h100));
    release_rst();
    for (int i = 0; i < 10 && bif.mem_req !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 20 && bif.mem_req === 1'b1; i++) begin
      hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 4 || bus_err !== 1'b1 || halted !== 1'b1 || retired !== 32'd0) begin
      failures++;
      $display("FAIL timeout got req_cycles=%0d bus_err=%b halted=%b retired=%0d want 4 1 1 0",
               hi, bus_err, halted, retired);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || bus_err !== 1'b0 || bif.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_reset got halted=%b bus_err=%b req=%b want 0 0 0", halted, bus_err, bif.mem_req);
    end
  endtask

  task automatic test_reset_mid_access();
    begin_run(3, 0);
    mem[30'h100] = 32'h0100_0005;
    mem[30'h101] = 32'h0211_0003;
    mem[30'h102] = 32'h0300_0007;
    exp_q.push_back(rd_acc(30'h100));
    exp_q.push_back(rd_acc(30'h101));
    exp_q.push_back(rd_acc(30'h102));
    release_rst();
    for (int i = 0; i < 100 && retired !== 32'd2; i++) @(negedge clk);
    for (int i = 0; i < 10 && bif.mem_req !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (bif.mem_req !== 1'b1 || bif.mem_addr !== 30'h102 || retired !== 32'd2) begin
      failures++;
      $display("FAIL mid_access_setup got req=%b addr=%h retired=%0d want 1 102 2", bif.mem_req, bif.mem_addr, retired);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bif.mem_req, bif.mem_we, halted, bus_err} !== 4'b0 || bif.mem_addr !== 30'h0 ||
        bif.mem_wdata !== 32'h0 || retired !== 32'h0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_access_reset got req=%b we=%b addr=%h wdata=%h halted=%b bus_err=%b retired=%0d pending=%0d want all 0",
               bif.mem_req, bif.mem_we, bif.mem_addr, bif.mem_wdata, halted, bus_err, retired, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    #3 rst = 1'b0;
    test_reset();
    test_load_store();
    test_wait_states();
    test_branch();
    test_trap();
    test_timeout();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
